// File: rtl/conv_input_seq.sv
// Upstream feeder for the convolution controller: turns a pixel/coefficient word stream into
// paced load pulses and row/column tracking. Define CONV_SEQ_FRAME_CNT_EN to add frame_count.
module conv_input_seq #(
  parameter int DATA_W   = 8,
  parameter int ROW_LEN  = 8,
  parameter int NUM_ROWS = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_is_coeff,
  output logic              in_ready,
  input  logic              modwait,
  output logic              sample_load_en,
  output logic              new_row,
  output logic              coeff_load_en,
  output logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] coeff_data,
  output logic [7:0]        col_count,
  output logic [7:0]        row_count,
  output logic              frame_done,
`ifdef CONV_SEQ_FRAME_CNT_EN
  output logic [7:0]        frame_count,
`endif
  output logic [2:0]        state_dbg_o
);

  typedef enum logic [2:0] {
    ST_READY    = 3'd0,
    ST_PULSE    = 3'd1,
    ST_HOLD     = 3'd2,
    ST_CF_PULSE = 3'd3,
    ST_CF_D0    = 3'd4,
    ST_CF_D1    = 3'd5,
    ST_CF_D2    = 3'd6
  } state_t;

  localparam logic [7:0] COL_LAST = 8'(ROW_LEN - 1);
  localparam logic [7:0] ROW_LAST = 8'(NUM_ROWS - 1);

  state_t            state_q;
  logic              sample_load_en_q, new_row_q, coeff_load_en_q, frame_done_q;
  logic [DATA_W-1:0] sample_data_q, coeff_data_q;
  logic [7:0]        col_q, row_q;
  logic              ctrl_idle_q, coeff_full_q;
  logic [1:0]        coeff_idx_q;
  logic [DATA_W-1:0] coeff_buf_q [3];
`ifdef CONV_SEQ_FRAME_CNT_EN
  logic [7:0]        frame_cnt_q;
`endif

  logic [7:0] col_d, row_d;
  logic       frame_end_d;
  logic       cf_go;
  logic       accept;

  // Handshake: a word transfers on a rising clk edge where in_valid && in_ready; in_valid may
  // drop at any time, and in_ready is only ever offered in READY while the controller is free.
  assign cf_go    = (state_q == ST_READY) && coeff_full_q && !ctrl_idle_q &&
                    (col_q >= 8'd3) && !modwait;
  assign in_ready = n_rst && (state_q == ST_READY) && !modwait &&
                    !(in_is_coeff && coeff_full_q) && !cf_go;
  assign accept   = in_valid && in_ready;

  always_comb begin
    col_d       = col_q + 8'd1;
    row_d       = row_q;
    frame_end_d = 1'b0;
    if (col_q == COL_LAST) begin
      col_d = 8'd0;
      if (row_q == ROW_LAST) begin
        row_d       = 8'd0;
        frame_end_d = 1'b1;
      end else begin
        row_d = row_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= ST_READY;
      sample_load_en_q <= 1'b0;
      new_row_q        <= 1'b0;
      coeff_load_en_q  <= 1'b0;
      frame_done_q     <= 1'b0;
      sample_data_q    <= '0;
      coeff_data_q     <= '0;
      col_q            <= 8'd0;
      row_q            <= 8'd0;
      ctrl_idle_q      <= 1'b1;
      coeff_full_q     <= 1'b0;
      coeff_idx_q      <= 2'd0;
      coeff_buf_q[0]   <= '0;
      coeff_buf_q[1]   <= '0;
      coeff_buf_q[2]   <= '0;
`ifdef CONV_SEQ_FRAME_CNT_EN
      frame_cnt_q      <= 8'd0;
`endif
    end else begin
      sample_load_en_q <= 1'b0;
      new_row_q        <= 1'b0;
      coeff_load_en_q  <= 1'b0;
      frame_done_q     <= 1'b0;
      case (state_q)
        ST_READY: begin
          if (cf_go) begin
            coeff_load_en_q <= 1'b1;
            coeff_data_q    <= coeff_buf_q[0];
            state_q         <= ST_CF_PULSE;
          end else if (accept && !in_is_coeff) begin
            sample_data_q <= in_data;
            state_q       <= ST_PULSE;
            // First pixel after idle primes the controller; later column-0 pixels start a row.
            if (col_q == 8'd0 && ctrl_idle_q) begin
              sample_load_en_q <= 1'b1;
              ctrl_idle_q      <= 1'b0;
            end else if (col_q == 8'd0) begin
              new_row_q <= 1'b1;
            end else begin
              sample_load_en_q <= 1'b1;
            end
          end else if (accept) begin
            case (coeff_idx_q)
              2'd0:    coeff_buf_q[0] <= in_data;
              2'd1:    coeff_buf_q[1] <= in_data;
              2'd2:    coeff_buf_q[2] <= in_data;
              default: ;
            endcase
            coeff_idx_q <= coeff_idx_q + 2'd1;
            if (coeff_idx_q == 2'd2) coeff_full_q <= 1'b1;
          end
        end
        ST_PULSE: begin
          col_q        <= col_d;
          row_q        <= row_d;
          frame_done_q <= frame_end_d;
`ifdef CONV_SEQ_FRAME_CNT_EN
          if (frame_end_d) frame_cnt_q <= frame_cnt_q + 8'd1;
`endif
          state_q <= ST_HOLD;
        end
        ST_HOLD: state_q <= ST_READY;
        ST_CF_PULSE: begin
          coeff_data_q <= coeff_buf_q[0];
          state_q      <= ST_CF_D0;
        end
        ST_CF_D0: begin
          coeff_data_q <= coeff_buf_q[1];
          state_q      <= ST_CF_D1;
        end
        ST_CF_D1: begin
          coeff_data_q <= coeff_buf_q[2];
          state_q      <= ST_CF_D2;
        end
        ST_CF_D2: begin
          // Controller is idle after a coefficient load, so the row is re-primed from column 0.
          ctrl_idle_q  <= 1'b1;
          col_q        <= 8'd0;
          coeff_full_q <= 1'b0;
          coeff_idx_q  <= 2'd0;
          state_q      <= ST_READY;
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

  assign sample_load_en = sample_load_en_q;
  assign new_row        = new_row_q;
  assign coeff_load_en  = coeff_load_en_q;
  assign frame_done     = frame_done_q;
  assign sample_data    = sample_data_q;
  assign coeff_data     = coeff_data_q;
  assign col_count      = col_q;
  assign row_count      = row_q;
  assign state_dbg_o    = state_q;
`ifdef CONV_SEQ_FRAME_CNT_EN
  assign frame_count    = frame_cnt_q;
`endif

endmodule

// File: tb/tb_conv_input_seq.sv
// Bench for conv_input_seq: randomized word stream against a position/coefficient model, with a
// modwait-driving controller stand-in and a queue-based monitor.
module tb_conv_input_seq;
  localparam int DW = 8;
  localparam int RL = 4;
  localparam int NR = 2;

  logic          clk;
  logic          n_rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_is_coeff;
  logic          in_ready;
  logic          modwait;
  logic          sample_load_en, new_row, coeff_load_en, frame_done;
  logic [DW-1:0] sample_data, coeff_data;
  logic [7:0]    col_count, row_count;
  logic [2:0]    dut_state;
`ifdef CONV_SEQ_FRAME_CNT_EN
  logic [7:0]    frame_count;
`endif

  conv_input_seq #(.DATA_W(DW), .ROW_LEN(RL), .NUM_ROWS(NR)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_data(in_data),
    .in_is_coeff(in_is_coeff), .in_ready(in_ready), .modwait(modwait),
    .sample_load_en(sample_load_en), .new_row(new_row), .coeff_load_en(coeff_load_en),
    .sample_data(sample_data), .coeff_data(coeff_data), .col_count(col_count),
    .row_count(row_count), .frame_done(frame_done),
`ifdef CONV_SEQ_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .state_dbg_o(dut_state)
  );

  // kind: 0 = sample_load_en, 1 = new_row, 2 = coeff_load_en
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] d0, d1, d2;
    logic [7:0] col_b, row_b, col_a, row_a;
    logic       fdone;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0, fails = 0;
  int   m_col, m_row, m_idle, m_full, m_nco, m_frames;
  logic [7:0] m_buf [3];
  bit   mon_en;
  int   last_pix;
  int   viol = 0;
  int   fd_seen = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model
  task automatic model_reset();
    m_col = 0; m_row = 0; m_idle = 1; m_full = 0; m_nco = 0; m_frames = 0;
    exp_q.delete();
    last_pix = -1;
  endtask

  task automatic model_cf_check();
    exp_t e;
    if (m_full != 0 && m_idle == 0 && m_col >= 3) begin
      e = '0;
      e.kind = 2'd2; e.d0 = m_buf[0]; e.d1 = m_buf[1]; e.d2 = m_buf[2];
      e.col_a = 8'd0; e.row_a = 8'(m_row);
      exp_q.push_back(e);
      m_col = 0; m_idle = 1; m_full = 0; m_nco = 0;
    end
  endtask

  task automatic model_pixel(input logic [7:0] d);
    exp_t e;
    e = '0;
    e.d0 = d; e.col_b = 8'(m_col); e.row_b = 8'(m_row);
    if (m_col == 0 && m_idle != 0) begin
      e.kind = 2'd0; m_idle = 0;
    end else if (m_col == 0) e.kind = 2'd1;
    else e.kind = 2'd0;
    m_col++;
    if (m_col == RL) begin
      m_col = 0; m_row++;
      if (m_row == NR) begin
        m_row = 0; e.fdone = 1'b1; m_frames++;
      end
    end
    e.col_a = 8'(m_col); e.row_a = 8'(m_row);
    exp_q.push_back(e);
    model_cf_check();
  endtask

  task automatic model_coeff(input logic [7:0] d);
    m_buf[m_nco] = d;
    m_nco++;
    if (m_nco == 3) m_full = 1;
    model_cf_check();
  endtask

  // driver tasks
  task automatic send_word(input logic [7:0] d, input bit c);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk); #1;
      in_valid = 1'b1; in_data = d; in_is_coeff = c;
      #1;
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1'b1;
        if (c) model_coeff(d);
        else model_pixel(d);
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      tests++; fails++;
      $display("FAIL send_timeout: word 0x%0h coeff=%0d never accepted", d, c);
    end
  endtask

  task automatic expect_block(input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    @(negedge clk); #1;
    in_valid = 1'b1; in_data = d; in_is_coeff = 1'b1;
    repeat (5) begin
      #1;
      if (in_ready) seen = 1'b1;
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    check("t4_coeff_backpressure", seen, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d expected events never seen", exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    n_rst = 1'b0; in_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sample_load_en", sample_load_en, 0);
    check("rst_new_row", new_row, 0);
    check("rst_coeff_load_en", coeff_load_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sample_data", sample_data, 0);
    check("rst_coeff_data", coeff_data, 0);
    check("rst_col_count", col_count, 0);
    check("rst_row_count", row_count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_state", dut_state, 0);
`ifdef CONV_SEQ_FRAME_CNT_EN
    check("rst_frame_count", frame_count, 0);
`endif
    #1 n_rst = 1'b1;
  endtask

  // controller stand-in: busy for a few cycles after each load pulse
  initial begin
    int busy;
    busy = 0;
    modwait = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        busy = 0; modwait = 1'b0;
      end else if (sample_load_en || new_row || coeff_load_en) begin
        busy = int'($urandom_range(2, 5)); modwait = 1'b1;
      end else if (busy > 0) begin
        busy--; modwait = (busy != 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #3;
      if (n_rst && in_ready && modwait) viol++;
    end
  end

  // monitor / scoreboard
  initial begin
    exp_t e;
    int   mcyc;
    mcyc = 0;
    forever begin
      @(negedge clk); mcyc++;
      if (!mon_en || !n_rst) continue;
      if ((32'(sample_load_en) + 32'(new_row) + 32'(coeff_load_en)) > 1)
        check("pulse_onehot", 32'(sample_load_en) + 32'(new_row) + 32'(coeff_load_en), 1);
      if (sample_load_en || new_row) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel_pulse", 1, 0);
          continue;
        end
        e = exp_q.pop_front();
        check("pulse_kind", new_row ? 1 : 0, e.kind);
        check("sample_data", sample_data, e.d0);
        check("col_before", col_count, e.col_b);
        check("row_before", row_count, e.row_b);
        if (last_pix >= 0) check("pulse_spacing_ge3", (mcyc - last_pix) >= 3, 1);
        last_pix = mcyc;
        @(negedge clk); mcyc++;
        if (frame_done) fd_seen++;
        check("col_after", col_count, e.col_a);
        check("row_after", row_count, e.row_a);
        check("frame_done", frame_done, e.fdone);
      end else if (coeff_load_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_coeff_load", 1, 0);
          continue;
        end
        e = exp_q.pop_front();
        check("cf_kind", 2, e.kind);
        check("cf_pulse_data", coeff_data, e.d0);
        @(negedge clk); mcyc++;
        check("cf_single_cycle", coeff_load_en, 0);
        check("cf_d0", coeff_data, e.d0);
        @(negedge clk); mcyc++;
        check("cf_d1", coeff_data, e.d1);
        @(negedge clk); mcyc++;
        check("cf_d2", coeff_data, e.d2);
        @(negedge clk); mcyc++;
        check("cf_col_reprime", col_count, e.col_a);
        check("cf_row_kept", row_count, e.row_a);
      end else if (frame_done) begin
        fd_seen++;
        check("stray_frame_done", 1, 0);
      end
    end
  end

  // stimulus
  initial begin
    bit seen_cf;
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; in_is_coeff = 1'b0;
    mon_en = 1'b1;
    model_reset();
    do_reset();

    // back-to-back pixels while priming
    send_word(8'h10, 0); send_word(8'h11, 0); send_word(8'h12, 0);
    drain();
    check("t1_col_count", col_count, 3);

    // finish the frame and start the next
    for (int i = 0; i < 6; i++) send_word(8'h20 + 8'(i), 0);
    drain();
    check("t2_frame_done_count", fd_seen, 1);
    check("t2_col_count", col_count, 1);
    check("t2_row_count", row_count, 0);

    // coefficient load mid-row
    send_word(8'h30, 0); send_word(8'h31, 0);
    send_word(8'h01, 1); send_word(8'h02, 1); send_word(8'h03, 1);
    send_word(8'h32, 0);
    drain();
    check("t3_col_count", col_count, 1);

    // coefficients while idle, then back-pressure on a fourth
    do_reset();
    send_word(8'hA1, 1); send_word(8'hA2, 1); send_word(8'hA3, 1);
    expect_block(8'hA4);
    send_word(8'h40, 0); send_word(8'h41, 0); send_word(8'h42, 0);
    drain();
    check("t4_col_after_cf", col_count, 0);

    // reset in the middle of a coefficient load
    mon_en = 1'b0;
    send_word(8'h50, 0); send_word(8'h51, 0); send_word(8'h52, 0);
    send_word(8'hB1, 1); send_word(8'hB2, 1); send_word(8'hB3, 1);
    seen_cf = 1'b0;
    for (int t = 0; t < 100 && !seen_cf; t++) begin
      @(negedge clk);
      if (coeff_load_en) seen_cf = 1'b1;
    end
    check("t5_cf_started", seen_cf, 1);
    @(negedge clk); @(negedge clk);
    check("t5_cf_d1_data", coeff_data, 8'hB2);
    #1 n_rst = 1'b0;
    #1;
    check("t5_rst_coeff_data", coeff_data, 0);
    check("t5_rst_pulses", {sample_load_en, new_row, coeff_load_en, frame_done}, 0);
    check("t5_rst_counts", {col_count, row_count}, 0);
    check("t5_rst_sample_data", sample_data, 0);
    model_reset();
    @(negedge clk); #1 n_rst = 1'b1;
    mon_en = 1'b1;
    send_word(8'h60, 0); send_word(8'h61, 0); send_word(8'h62, 0);
    drain();
    repeat (20) @(negedge clk);
    check("t5_col_count", col_count, 3);

    // randomized stream
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0 && m_full == 0) send_word(8'($urandom), 1);
      else send_word(8'($urandom), 0);
    end
    drain();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_col_count", col_count, m_col);
    check("final_row_count", row_count, m_row);
`ifdef CONV_SEQ_FRAME_CNT_EN
    check("final_frame_count", frame_count, m_frames % 256);
`endif
    check("in_ready_while_modwait", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
